// File: rtl/bounce_measure_ctrl_if.sv
// ============================================================================
// Module   : bounce_measure_ctrl_if
// Brief    : Request/tick inputs and frozen-result outputs of the bounce
//            measurement sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bounce_measure_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         abort;
    logic         raw_tick;
    logic         db_tick;
    logic [W-1:0] raw_cnt;
    logic [W-1:0] db_cnt;
    logic         busy;
    logic         valid;
    logic         done_tick;
    logic         ovf;

    modport master (
        output start, abort, raw_tick, db_tick,
        input  raw_cnt, db_cnt, busy, valid, done_tick, ovf
    );

    modport slave (
        input  start, abort, raw_tick, db_tick,
        output raw_cnt, db_cnt, busy, valid, done_tick, ovf
    );
endinterface

`default_nettype wire

// File: rtl/bounce_measure_ctrl.sv
// ============================================================================
// Module   : bounce_measure_ctrl
// Brief    : Arms on start, counts raw and debounced ticks over a fixed window
//            starting at the first tick, then freezes the results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounce_measure_ctrl #(
    parameter int W          = 8,
    parameter int WIN_CYCLES = 50_000_000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    bounce_measure_ctrl_if.slave   bus
);

    localparam int           c_TW   = $clog2(WIN_CYCLES);
    localparam logic [c_TW-1:0] c_LOAD = c_TW'(WIN_CYCLES - 2);
    localparam logic [W-1:0] c_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic [W-1:0]    r_raw;
    logic [W-1:0]    r_db;
    logic            r_ovf;
    logic            r_done;
    logic            r_busy;
    logic            r_valid;

    logic w_any_tick;
    logic w_counting;
    logic w_raw_sat;
    logic w_db_sat;

    assign w_any_tick = bus.raw_tick | bus.db_tick;
    // The arm cycle is part of the window, so its ticks count as well
    assign w_counting = (r_state == S_MEASURE) || ((r_state == S_ARMED) && w_any_tick);
    assign w_raw_sat  = (r_raw == c_MAX);
    assign w_db_sat   = (r_db  == c_MAX);

    always_ff @(posedge clk) begin
        if (!reset || bus.abort) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_raw   <= '0;
            r_db    <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_ARMED;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_raw   <= '0;
                        r_db    <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_any_tick) begin
                        r_state <= S_MEASURE;
                        r_timer <= c_LOAD;
                    end
                end
                S_MEASURE: begin
                    if (r_timer == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase

            if (w_counting) begin
                if (bus.raw_tick && !w_raw_sat) begin
                    r_raw <= r_raw + 1'b1;
                end
                if (bus.db_tick && !w_db_sat) begin
                    r_db <= r_db + 1'b1;
                end
                if ((bus.raw_tick && w_raw_sat) || (bus.db_tick && w_db_sat)) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.raw_cnt   = r_raw;
    assign bus.db_cnt    = r_db;
    assign bus.busy      = r_busy;
    assign bus.valid     = r_valid;
    assign bus.done_tick = r_done;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire
